// File: rtl/arp_tx_if.sv
// ----------------------------------------------------------------------------
// arp_tx_if
// Byte-wide AXI-Stream style link carrying ARP frames towards the MAC TX path.
//
// Signals:
//   tdata  [7:0]  frame byte
//   tvalid        byte valid
//   tready        sink accepts the byte this cycle
//   tlast         marks the final byte of a frame
//
// Modports:
//   master - frame source (drives tdata/tvalid/tlast, samples tready)
//   slave  - frame sink   (drives tready, samples tdata/tvalid/tlast)
// ----------------------------------------------------------------------------
interface arp_tx_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/arp_tx.sv
// ----------------------------------------------------------------------------
// arp_tx
// Transmit-side ARP frame generator. Builds 60-byte Ethernet/ARP frames
// (reply or request, FCS added downstream) and streams them byte by byte.
//
// Parameters:
//   LOCAL_MAC      own MAC address (Ethernet source and SHA)
//   LOCAL_IP       own IPv4 address (SPA)
//   REQ_TARGET_IP  TPA placed in request frames
//
// Ports:
//   aclk            clock
//   aresetn         asynchronous active-low reset
//   arp_resp_start  level; a rising edge asks for a reply frame
//   arp_resp_end    one-cycle pulse after a reply frame has been sent
//   arp_rq_start    one-cycle pulse asking for a request frame
//   arp_rq_end      one-cycle pulse after a request frame has been sent
//   mac_d_addr_in   requester MAC (reply destination and THA)
//   ip_d_addr_in    requester IP (reply TPA)
//   m_axis          byte stream master (tdata/tvalid/tready/tlast)
// ----------------------------------------------------------------------------
module arp_tx #(
    parameter logic [47:0] LOCAL_MAC     = 48'h02_00_00_00_00_01,
    parameter logic [31:0] LOCAL_IP      = 32'hC0A8_010A,
    parameter logic [31:0] REQ_TARGET_IP = 32'hC0A8_0101
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        arp_resp_start,
    output logic        arp_resp_end,
    input  logic        arp_rq_start,
    output logic        arp_rq_end,
    input  logic [47:0] mac_d_addr_in,
    input  logic [31:0] ip_d_addr_in,
    arp_tx_if.master    m_axis
);

    // Bytes 0..41 carry header content; 42..59 are zero padding.
    localparam int         HDR_BYTES = 42;
    localparam logic [5:0] LAST_BYTE = 6'd59;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [5:0]  cnt_reg, cnt_next;
    logic        resp_prev_reg;
    logic        resp_pend_reg, resp_pend_next;
    logic        rq_pend_reg, rq_pend_next;
    logic        is_reply_reg, is_reply_next;
    logic [47:0] mac_reg, mac_next;
    logic [31:0] ip_reg, ip_next;

    logic        resp_rise;
    logic        start_reply;
    logic        start_req;

    // Edge detection: a level held high across the end pulse must not
    // produce a second reply.
    assign resp_rise = arp_resp_start & ~resp_prev_reg;

    // Pending flags collect triggers arriving in any state; several
    // triggers before the frame starts merge into one frame.
    assign resp_pend_next = (resp_pend_reg | resp_rise)    & ~start_reply;
    assign rq_pend_next   = (rq_pend_reg   | arp_rq_start) & ~start_req;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            resp_prev_reg <= 1'b0;
            resp_pend_reg <= 1'b0;
            rq_pend_reg   <= 1'b0;
            is_reply_reg  <= 1'b0;
            mac_reg       <= '0;
            ip_reg        <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            resp_prev_reg <= arp_resp_start;
            resp_pend_reg <= resp_pend_next;
            rq_pend_reg   <= rq_pend_next;
            is_reply_reg  <= is_reply_next;
            mac_reg       <= mac_next;
            ip_reg        <= ip_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        is_reply_next = is_reply_reg;
        mac_next      = mac_reg;
        ip_next       = ip_reg;
        start_reply   = 1'b0;
        start_req     = 1'b0;
        m_axis.tvalid = 1'b0;
        m_axis.tlast  = 1'b0;
        arp_resp_end  = 1'b0;
        arp_rq_end    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Reply wins when both are pending; the request stays
                // pending and goes out right after.
                if (resp_pend_reg || resp_rise) begin
                    start_reply = 1'b1;
                end else if (rq_pend_reg || arp_rq_start) begin
                    start_req = 1'b1;
                end
                if (start_reply || start_req) begin
                    state_next    = ST_SEND;
                    cnt_next      = '0;
                    is_reply_next = start_reply;
                    mac_next      = mac_d_addr_in;
                    ip_next       = ip_d_addr_in;
                end
            end

            ST_SEND: begin
                m_axis.tvalid = 1'b1;
                m_axis.tlast  = (cnt_reg == LAST_BYTE);
                if (m_axis.tready) begin
                    if (cnt_reg == LAST_BYTE) begin
                        state_next = ST_DONE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 6'd1;
                    end
                end
            end

            ST_DONE: begin
                arp_resp_end = is_reply_reg;
                arp_rq_end   = ~is_reply_reg;
                state_next   = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Frame content is derived from the snapshot only, so tdata cannot move
    // while a byte is stalled.
    logic [47:0]            dst_mac;
    logic [47:0]            tha;
    logic [31:0]            tpa;
    logic [15:0]            oper;
    logic [HDR_BYTES*8-1:0] hdr_vec;
    logic [7:0]             hdr_bytes [HDR_BYTES];

    assign dst_mac = is_reply_reg ? mac_reg : 48'hFFFF_FFFF_FFFF;
    assign tha     = is_reply_reg ? mac_reg : 48'h0;
    assign tpa     = is_reply_reg ? ip_reg  : REQ_TARGET_IP;
    assign oper    = is_reply_reg ? 16'h0002 : 16'h0001;

    // Ethernet header + ARP body, most significant byte = frame byte 0.
    assign hdr_vec = {dst_mac, LOCAL_MAC, 16'h0806,
                      16'h0001, 16'h0800, 8'h06, 8'h04, oper,
                      LOCAL_MAC, LOCAL_IP, tha, tpa};

    generate
        for (genvar gi = 0; gi < HDR_BYTES; gi++) begin : g_hdr_byte
            assign hdr_bytes[gi] = hdr_vec[(HDR_BYTES-1-gi)*8 +: 8];
        end
    endgenerate

    assign m_axis.tdata = (state_reg == ST_SEND && cnt_reg < 6'(HDR_BYTES))
                          ? hdr_bytes[cnt_reg] : 8'h00;

endmodule

// File: tb/tb_arp_tx.sv
module tb_arp_tx;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        arp_resp_start;
    logic        arp_resp_end;
    logic        arp_rq_start;
    logic        arp_rq_end;
    logic [47:0] mac_d_addr_in;
    logic [31:0] ip_d_addr_in;
    bit          rand_mode;

    arp_tx_if axis_bus ();

    arp_tx dut (
        .aclk           (clk),
        .aresetn        (aresetn),
        .arp_resp_start (arp_resp_start),
        .arp_resp_end   (arp_resp_end),
        .arp_rq_start   (arp_rq_start),
        .arp_rq_end     (arp_rq_end),
        .mac_d_addr_in  (mac_d_addr_in),
        .ip_d_addr_in   (ip_d_addr_in),
        .m_axis         (axis_bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // tready: held high, or random ~50 % when rand_mode is set
    always @(posedge clk) begin
        #1;
        axis_bus.tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] exp_q [$];     // {tlast, tdata}
    logic [1:0] end_q [$];     // {resp_end, rq_end}
    int         first_q [$];   // cycle of byte 0 of each frame
    int         last_q  [$];   // cycle of tlast byte
    int         endc_q  [$];   // cycle of end pulse

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input bit reply, input logic [47:0] mac, input logic [31:0] ip);
        logic [7:0]  f [60];
        logic [47:0] lmac;
        logic [31:0] lip;
        logic [31:0] rtip;
        lmac = 48'h02_00_00_00_00_01;
        lip  = 32'hC0A8_010A;
        rtip = 32'hC0A8_0101;
        for (int i = 0; i < 60; i++) f[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            f[i]      = reply ? mac[47-8*i -: 8] : 8'hFF;
            f[6+i]    = lmac[47-8*i -: 8];
            f[22+i]   = lmac[47-8*i -: 8];
            f[32+i]   = reply ? mac[47-8*i -: 8] : 8'h00;
        end
        f[12] = 8'h08; f[13] = 8'h06; f[14] = 8'h00; f[15] = 8'h01;
        f[16] = 8'h08; f[17] = 8'h00; f[18] = 8'h06; f[19] = 8'h04;
        f[20] = 8'h00; f[21] = reply ? 8'h02 : 8'h01;
        for (int i = 0; i < 4; i++) begin
            f[28+i] = lip[31-8*i -: 8];
            f[38+i] = reply ? ip[31-8*i -: 8] : rtip[31-8*i -: 8];
        end
        for (int i = 0; i < 60; i++) exp_q.push_back({(i == 59), f[i]});
        end_q.push_back(reply ? 2'b10 : 2'b01);
    endtask

    task automatic clear_logs();
        first_q.delete();
        last_q.delete();
        endc_q.delete();
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        for (int i = 0; i < max_cyc; i++) begin
            if (exp_q.size() == 0 && end_q.size() == 0) break;
            @(posedge clk);
        end
        check({name, " drained"}, 64'(exp_q.size() + end_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a byte or pulse
    int         byte_idx = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        logic [8:0] e;
        logic [1:0] ee;
        if (!aresetn) begin
            byte_idx   = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && axis_bus.tvalid)
                check("hold", 64'(axis_bus.tdata), 64'(prev_data));
            prev_stall = axis_bus.tvalid && !axis_bus.tready;
            prev_data  = axis_bus.tdata;
            if (axis_bus.tvalid && axis_bus.tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected byte: got %0h expected none", axis_bus.tdata);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("byte%0d", byte_idx), 64'({axis_bus.tlast, axis_bus.tdata}), 64'(e));
                end
                if (byte_idx == 0) first_q.push_back(cyc);
                if (axis_bus.tlast) begin
                    last_q.push_back(cyc);
                    byte_idx = 0;
                end else begin
                    byte_idx++;
                end
            end
        end
        if (arp_resp_end || arp_rq_end) begin
            endc_q.push_back(cyc);
            if (end_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected end pulse: got %0b%0b expected none", arp_resp_end, arp_rq_end);
            end else begin
                ee = end_q.pop_front();
                check("end pulse", 64'({arp_resp_end, arp_rq_end}), 64'(ee));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int trig;
        aresetn        = 1'b0;
        arp_resp_start = 1'b0;
        arp_rq_start   = 1'b0;
        mac_d_addr_in  = '0;
        ip_d_addr_in   = '0;
        rand_mode      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset tvalid", 64'(axis_bus.tvalid), 64'd0);
        check("reset tlast",  64'(axis_bus.tlast),  64'd0);
        check("reset tdata",  64'(axis_bus.tdata),  64'd0);
        check("reset ends",   64'({arp_resp_end, arp_rq_end}), 64'd0);
        @(posedge clk); #1;
        aresetn = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Reply frame, tready high, latency checks
        $display("txn reply: mac 112233445566 ip c0a80105");
        clear_logs();
        mac_d_addr_in = 48'h1122_3344_5566;
        ip_d_addr_in  = 32'hC0A8_0105;
        push_frame(1'b1, mac_d_addr_in, ip_d_addr_in);
        arp_resp_start = 1'b1;
        trig = cyc;
        wait_idle(100, "reply");
        check("reply first cycle", 64'(first_q[0] - trig), 64'd1);
        check("reply tlast cycle", 64'(last_q[0] - trig),  64'd60);
        check("reply end cycle",   64'(endc_q[0] - trig),  64'd61);
        arp_resp_start = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Request frame
        $display("txn request pulse");
        clear_logs();
        push_frame(1'b0, 48'h0, 32'h0);
        arp_rq_start = 1'b1;
        trig = cyc;
        @(posedge clk); #1;
        arp_rq_start = 1'b0;
        wait_idle(100, "request");
        check("request first cycle", 64'(first_q[0] - trig), 64'd1);
        check("request end cycle",   64'(endc_q[0] - trig),  64'd61);

        // Simultaneous reply rise and request pulse
        $display("txn simultaneous reply+request");
        clear_logs();
        mac_d_addr_in = 48'hA1B2_C3D4_E5F6;
        ip_d_addr_in  = 32'h0A00_0007;
        push_frame(1'b1, mac_d_addr_in, ip_d_addr_in);
        push_frame(1'b0, 48'h0, 32'h0);
        arp_resp_start = 1'b1;
        arp_rq_start   = 1'b1;
        @(posedge clk); #1;
        arp_rq_start = 1'b0;
        wait_idle(200, "simultaneous");
        check("simul frame count", 64'(last_q.size()), 64'd2);
        check("simul gap", 64'(first_q[1] - last_q[0]), 64'd3);
        arp_resp_start = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Request pulsed mid-reply
        $display("txn request during reply");
        clear_logs();
        mac_d_addr_in = 48'h0000_0000_0009;
        ip_d_addr_in  = 32'hC0A8_0163;
        push_frame(1'b1, mac_d_addr_in, ip_d_addr_in);
        push_frame(1'b0, 48'h0, 32'h0);
        arp_resp_start = 1'b1;
        repeat (20) @(posedge clk); #1;
        arp_rq_start = 1'b1;
        @(posedge clk); #1;
        arp_rq_start = 1'b0;
        wait_idle(200, "mid-reply request");
        check("mid gap", 64'(first_q[1] - last_q[0]), 64'd3);
        arp_resp_start = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Random backpressure
        $display("txn reply with random tready");
        rand_mode = 1'b1;
        mac_d_addr_in = 48'hDEAD_BEEF_0042;
        ip_d_addr_in  = 32'hAC10_2030;
        push_frame(1'b1, mac_d_addr_in, ip_d_addr_in);
        arp_resp_start = 1'b1;
        wait_idle(400, "backpressure");
        arp_resp_start = 1'b0;
        rand_mode = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Level held long after the end pulse: exactly one frame
        $display("txn reply start held 200 cycles");
        clear_logs();
        mac_d_addr_in = 48'h1122_3344_5566;
        ip_d_addr_in  = 32'hC0A8_0105;
        push_frame(1'b1, mac_d_addr_in, ip_d_addr_in);
        arp_resp_start = 1'b1;
        wait_idle(100, "held");
        repeat (200) @(posedge clk); #1;
        check("held frame count", 64'(last_q.size()), 64'd1);
        arp_resp_start = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Reset at byte 30
        $display("txn reset mid-frame");
        clear_logs();
        push_frame(1'b1, mac_d_addr_in, ip_d_addr_in);
        arp_resp_start = 1'b1;
        repeat (31) @(posedge clk);
        #1;
        check("byte30 before reset", 64'(axis_bus.tdata), 64'h01);
        aresetn        = 1'b0;
        arp_resp_start = 1'b0;
        exp_q.delete();
        end_q.delete();
        #1;
        check("async tvalid", 64'(axis_bus.tvalid), 64'd0);
        check("async tlast",  64'(axis_bus.tlast),  64'd0);
        repeat (3) @(posedge clk); #1;
        aresetn = 1'b1;
        repeat (5) @(posedge clk); #1;
        check("no end after reset", 64'(endc_q.size()), 64'd0);

        $display("txn reply after reset");
        clear_logs();
        mac_d_addr_in = 48'h0102_0304_0506;
        ip_d_addr_in  = 32'hC0A8_01FE;
        push_frame(1'b1, mac_d_addr_in, ip_d_addr_in);
        arp_resp_start = 1'b1;
        trig = cyc;
        wait_idle(100, "post-reset");
        check("post-reset first cycle", 64'(first_q[0] - trig), 64'd1);
        arp_resp_start = 1'b0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
